// File: rtl/demux2_stream_pkg.sv
// Shared defaults for the 1-to-2 stream demultiplexer.
package demux2_stream_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with a valid/ready handshake.
// A load and a drain in the same cycle reload the slot with no bubble.
module demux_slot
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  input  logic             Ready,
  output logic             Free
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // The slot can take a word when it is empty or is being drained this cycle.
  assign Free  = !valid_q || Ready;
  assign Q     = data_q;
  assign Valid = valid_q;

  // Next state: a load wins over a drain; data is held while stalled.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (Load) begin
      data_d  = D;
      valid_d = 1'b1;
    end else if (valid_q && Ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register; reset discards any held word.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: steers each accepted word to
// channel A or B and keeps a wrapping per-channel accept counter.
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  input  logic             In_Select,
  output logic             In_Ready,
  output logic [WIDTH-1:0] A_Data,
  output logic             A_Valid,
  input  logic             A_Ready,
  output logic [WIDTH-1:0] B_Data,
  output logic             B_Valid,
  input  logic             B_Ready,
  output logic [CNT_W-1:0] Count_A,
  output logic [CNT_W-1:0] Count_B
);

  logic             a_free, b_free;
  logic             load_a, load_b;
  logic [CNT_W-1:0] count_a_q, count_a_d;
  logic [CNT_W-1:0] count_b_q, count_b_d;

  // Readiness depends only on the selected slot, never on In_Valid.
  assign In_Ready = In_Select ? b_free : a_free;
  assign load_a   = In_Valid && In_Ready && !In_Select;
  assign load_b   = In_Valid && In_Ready &&  In_Select;

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Load  (load_a),
    .D     (In_Data),
    .Q     (A_Data),
    .Valid (A_Valid),
    .Ready (A_Ready),
    .Free  (a_free)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Load  (load_b),
    .D     (In_Data),
    .Q     (B_Data),
    .Valid (B_Valid),
    .Ready (B_Ready),
    .Free  (b_free)
  );

  // Accept counters advance on every load and wrap silently.
  always_comb begin
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    if (load_a) count_a_d = count_a_q + CNT_W'(1);
    if (load_b) count_b_d = count_b_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count_a_q <= '0;
      count_b_q <= '0;
    end else begin
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
    end
  end

  assign Count_A = count_a_q;
  assign Count_B = count_b_q;

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench: stimulus pushes expected words per channel, a monitor
// pops and compares on every output handshake.
module tb_demux2_stream;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [W-1:0]  In_Data;
  logic          In_Valid, In_Select, In_Ready;
  logic [W-1:0]  A_Data, B_Data;
  logic          A_Valid, A_Ready, B_Valid, B_Ready;
  logic [CW-1:0] Count_A, Count_B;

  int checks = 0;
  int failures = 0;
  int exp_a = 0;
  int exp_b = 0;
  int stalls = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  always #5 Clk = ~Clk;

  demux2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Select(In_Select), .In_Ready(In_Ready),
    .A_Data(A_Data), .A_Valid(A_Valid), .A_Ready(A_Ready),
    .B_Data(B_Data), .B_Valid(B_Valid), .B_Ready(B_Ready),
    .Count_A(Count_A), .Count_B(Count_B)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each output handshake must deliver the oldest expected word.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1) begin
      if (A_Valid && A_Ready) begin
        if (qa.size() == 0) chk("a_unexpected", 32'(A_Data), 32'hFFFF_FFFF);
        else chk("a_data", 32'(A_Data), 32'(qa.pop_front()));
      end
      if (B_Valid && B_Ready) begin
        if (qb.size() == 0) chk("b_unexpected", 32'(B_Data), 32'hFFFF_FFFF);
        else chk("b_data", 32'(B_Data), 32'(qb.pop_front()));
      end
    end
  end

  // Present a word and hold it until accepted (bounded wait).
  task automatic send(input logic s, input logic [W-1:0] d);
    int n = 0;
    In_Valid = 1'b1; In_Select = s; In_Data = d;
    forever begin
      @(negedge Clk);
      if (In_Ready) begin
        if (s) begin qb.push_back(d); exp_b++; end
        else   begin qa.push_back(d); exp_a++; end
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        return;
      end
      stalls++;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'(n), 32'd0);
        In_Valid = 1'b0;
        return;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    Rst_n = 1'b0;
    repeat (cycles) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    qa.delete(); qb.delete();
    exp_a = 0; exp_b = 0;
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_cnt_a"}, 32'(Count_A), 32'(exp_a % 16));
    chk({name, "_cnt_b"}, 32'(Count_B), 32'(exp_b % 16));
  endtask

  initial begin
    Rst_n = 1'b0; In_Valid = 1'b1; In_Select = 1'b0; In_Data = 8'h55;
    A_Ready = 1'b1; B_Ready = 1'b1;

    // Reset with a transfer presented: nothing accepted.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_a_valid", 32'(A_Valid), 32'd0);
    chk("rst_b_valid", 32'(B_Valid), 32'd0);
    chk("rst_a_data", 32'(A_Data), 32'd0);
    chk("rst_b_data", 32'(B_Data), 32'd0);
    chk("rst_cnt_a", 32'(Count_A), 32'd0);
    chk("rst_cnt_b", 32'(Count_B), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1; In_Valid = 1'b0;
    @(negedge Clk);
    chk("rst_in_ready", 32'(In_Ready), 32'd1);
    @(posedge Clk); #1;

    // Steering.
    send(1'b0, 8'h11);
    @(negedge Clk);
    chk("steer_a_valid", 32'(A_Valid), 32'd1);
    chk("steer_a_data", 32'(A_Data), 32'h11);
    @(posedge Clk); #1;
    send(1'b1, 8'hA5);
    @(negedge Clk);
    chk("steer_b_data", 32'(B_Data), 32'hA5);
    chk_counts("steer");
    @(posedge Clk); #1;

    // Backpressure on A.
    A_Ready = 1'b0;
    send(1'b0, 8'h01);
    In_Valid = 1'b1; In_Select = 1'b0; In_Data = 8'h02;
    repeat (2) begin
      @(negedge Clk);
      chk("bp_in_ready", 32'(In_Ready), 32'd0);
      chk("bp_a_held", 32'(A_Data), 32'h01);
      @(posedge Clk); #1;
    end
    send(1'b1, 8'h03);
    In_Valid = 1'b1; In_Select = 1'b0; In_Data = 8'h02; A_Ready = 1'b1;
    @(negedge Clk);
    chk("bp_release_ready", 32'(In_Ready), 32'd1);
    qa.push_back(8'h02); exp_a++;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    @(negedge Clk);
    chk("bp_a_valid_kept", 32'(A_Valid), 32'd1);
    chk("bp_a_data_new", 32'(A_Data), 32'h02);
    chk_counts("bp");
    @(posedge Clk); #1;

    // Full throughput: 16 alternating words, no stalls.
    do_reset(1);
    stalls = 0;
    for (int i = 0; i < 16; i++) send(i[0], 8'(8'h40 + i));
    chk("tp_stalls", 32'(stalls), 32'd0);
    @(negedge Clk);
    chk_counts("tp");
    @(posedge Clk); #1;

    // Wrap: 17 words to B on a 4-bit counter.
    do_reset(1);
    for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h80 + i));
    @(negedge Clk);
    chk("wrap_cnt_b", 32'(Count_B), 32'd1);
    chk("wrap_cnt_a", 32'(Count_A), 32'd0);
    @(posedge Clk); #1;

    // Reset mid-operation with both slots full and stalled.
    do_reset(1);
    A_Ready = 1'b0; B_Ready = 1'b0;
    send(1'b0, 8'h77);
    send(1'b1, 8'h88);
    @(negedge Clk);
    chk("mid_a_full", 32'(A_Valid), 32'd1);
    chk("mid_b_full", 32'(B_Valid), 32'd1);
    @(posedge Clk); #1;
    Rst_n = 1'b0; In_Valid = 1'b1; In_Select = 1'b0; In_Data = 8'hEE;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    qa.delete(); qb.delete();
    @(negedge Clk);
    chk("mid_a_valid", 32'(A_Valid), 32'd0);
    chk("mid_b_valid", 32'(B_Valid), 32'd0);
    chk("mid_cnt_a", 32'(Count_A), 32'd0);
    chk("mid_cnt_b", 32'(Count_B), 32'd0);
    Rst_n = 1'b1; A_Ready = 1'b1; B_Ready = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("end_qa_empty", 32'(qa.size()), 32'd0);
    chk("end_qb_empty", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer. It is the distributing counterpart of the 2:1 selection mux used in the carry-select datapath. Each accepted input word is steered by `In_Select` to one of two output channels, A or B. Each channel is a one-entry registered slot with a valid/ready handshake, and a wrapping per-channel transfer counter is kept. It sits in front of paired datapath lanes, such as duplicated adder sections, that consume operands independently.

## Interface
- `WIDTH`, 8: data width of input and both outputs.
- `CNT_W`, 16: width of each per-channel accept counter.

- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  reset, synchronous and active-low.
- `In_Data`  in  WIDTH  input word.
- `In_Valid`  in  1  input word present.
- `In_Select`  in  1  steering: 0 sends the word to A, 1 sends it to B.
- `In_Ready`  out  1  input word accepted this cycle when high together with `In_Valid`.
- `A_Data`  out  WIDTH  channel A word.
- `A_Valid`  out  1  channel A slot full.
- `A_Ready`  in  1  channel A consumer accepts.
- `B_Data`, `B_Valid`, `B_Ready`: same as the A ports, for channel B.
- `Count_A`  out  CNT_W  words accepted into A, wrapping.
- `Count_B`  out  CNT_W  words accepted into B, wrapping.

## Operation
- Each channel X ∈ {A,B} is a slot with two states, EMPTY (`X_Valid`=0) and FULL (`X_Valid`=1).
- Slot X can take a word when `X_free` = !`X_Valid` | `X_Ready`.
- `In_Ready` = `In_Select` ? `B_free` : `A_free`. This is combinational from `In_Select`, `X_Valid` and `X_Ready`; there is no combinational path from `In_Valid`.
- Accept into X: `In_Valid` & `In_Ready` & (`In_Select` selects X). The slot loads `In_Data`, goes FULL, and `Count_X` increments.
- Drain of X: `X_Valid` & `X_Ready`. If there is no simultaneous accept into X, the slot goes EMPTY.
- Drain and accept on X in the same cycle: the slot reloads with the new word and `X_Valid` stays 1. There is no bubble, so throughput is 1 word/cycle per channel.
- The non-selected channel is unaffected by the input. It may drain in the same cycle.
- While `X_Valid`=1 and `X_Ready`=0, `X_Data` is held stable.
- `In_Select` and `In_Data` are only sampled when a transfer happens. If `In_Valid`=0, `In_Select` may toggle freely without side effects.
- Counters wrap from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset (`Rst_n`=0 at a rising edge):
  - `A_Valid`=`B_Valid`=0.
  - `A_Data`=`B_Data`=0.
  - `Count_A`=`Count_B`=0.
  - `In_Ready` then evaluates to 1, because both slots are free.
- Reset mid-operation discards any held words with no drain. A transfer presented in the reset cycle is not accepted and not counted.
- Latency: a word accepted at edge n appears on `X_Data`/`X_Valid` from edge n (visible in cycle n+1). `Count_X` updates at the same edge.
- Backpressure: if slot X is FULL and `X_Ready`=0, then `In_Ready`=0 whenever `In_Select` selects X. The other channel still accepts when `In_Select` selects it.
- All state updates are on the rising edge of `Clk` only. There are no asynchronous paths.

## Structure
- Shared package/header: no block-specific types. Only `WIDTH`/`CNT_W` defaults, if the team's common constants file is used.
- Sub-module `demux_slot` (parameter WIDTH), instantiated twice. Its ports are `Clk`, `Rst_n`, `Load`, `D`, `Q`, `Valid`, `Ready`, `Free`.
- Counters and the steering logic live in the top module.

## Test plan
- Reset: hold `Rst_n`=0 for 2 cycles with `In_Valid`=1 → both Valid=0, both Data=0, both counts 0, nothing accepted. Release → `In_Ready`=1.
- Steering: send 0x11 with Select=0, then 0xA5 with Select=1, both outputs Ready=1 → `A_Data`=0x11 one edge after accept; `B_Data`=0xA5 next; `Count_A`=1, `Count_B`=1.
- Backpressure on A: `A_Ready`=0, send 0x01 then 0x02 to A → 0x01 held; `In_Ready`=0 for the second word. Send 0x03 to B meanwhile → accepted. Raise `A_Ready` → 0x02 is accepted the same cycle 0x01 drains, and `A_Valid` stays 1.
- Full throughput: 16 back-to-back words alternating Select with both Ready=1 → `In_Ready` stays 1; every word appears on its channel in order; counts = 8/8.
- Wrap: with `CNT_W`=4, push 17 words to B → `Count_B`=1 and `Count_A`=0.
- Reset mid-operation: both slots FULL with Ready=0, assert `Rst_n`=0 → both Valid=0 and counts 0 after the edge; no output handshake occurs.
